// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the branch predict unit: opcodes, flag
// positions, 2-bit direction counter states and branch resolution functions.
package branch_predict_unit_pkg;

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BRZ  = 4'h2;
  localparam logic [3:0] OP_BRNZ = 4'h3;
  localparam logic [3:0] OP_BRNS = 4'h4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;

  typedef enum logic [1:0] {
    SC_SNT = 2'b00,
    SC_WNT = 2'b01,
    SC_WT  = 2'b10,
    SC_ST  = 2'b11
  } sc_state_e;

  function automatic logic is_known_op(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_BRZ) || (op == OP_BRNZ) || (op == OP_BRNS);
  endfunction

  function automatic logic is_cond_op(input logic [3:0] op);
    return (op == OP_BRZ) || (op == OP_BRNZ) || (op == OP_BRNS);
  endfunction

  // Unknown opcodes resolve not-taken so they can never redirect fetch.
  function automatic logic resolve_taken(input logic [3:0] op, input logic [3:0] flags);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_BRZ:  taken = flags[FLAG_Z];
      OP_BRNZ: taken = ~flags[FLAG_Z];
      OP_BRNS: taken = ~flags[FLAG_N];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// One 2-bit saturating direction counter; resets to weak-not-taken.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc_i,
  input  logic      dec_i,
  output sc_state_e cnt_o
);

  sc_state_e cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != SC_ST)) begin
      cnt_d = sc_state_e'(cnt_q + 2'd1);
    end else if (dec_i && (cnt_q != SC_SNT)) begin
      cnt_d = sc_state_e'(cnt_q - 2'd1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= SC_WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: registered fetch prediction, registered execute resolution
// and perf counters. Direction table is built only when BRANCH_PREDICT_EN is defined.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int OFF_W = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid_i,
  input  logic [PC_W-1:0]  f_pc_i,
  input  logic [OFF_W-1:0] f_offset_i,
  input  logic             f_uncond_i,
  output logic             p_valid_o,
  output logic             p_taken_o,
  output logic [PC_W-1:0]  p_target_o,
  input  logic             e_valid_i,
  input  logic [PC_W-1:0]  e_pc_i,
  input  logic [3:0]       e_type_i,
  input  logic [OFF_W-1:0] e_offset_i,
  input  logic [3:0]       e_flags_i,
  input  logic             e_pred_taken_i,
  output logic             r_valid_o,
  output logic             r_taken_o,
  output logic [PC_W-1:0]  r_target_o,
  output logic             r_mispredict_o,
  output logic [PC_W-1:0]  r_redirect_pc_o,
  output logic [CNT_W-1:0] n_branches_o,
  output logic [CNT_W-1:0] n_mispredicts_o
);

  // Size cast of a signed operand sign-extends (or truncates) to PC_W.
  function automatic logic [PC_W-1:0] calc_target(input logic [PC_W-1:0] pc,
                                                  input logic [OFF_W-1:0] off);
    return pc + PC_W'(1) + PC_W'($signed(off));
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic e_taken_s, e_known_s, pred_dir_s;
  assign e_taken_s = resolve_taken(e_type_i, e_flags_i);
  assign e_known_s = is_known_op(e_type_i);

`ifdef BRANCH_PREDICT_EN
  localparam int N_ENT = 1 << IDX_W;
  sc_state_e cnt_s [N_ENT];
  logic      upd_s;
  logic [1:0] f_cnt_s;
  assign upd_s = e_valid_i && is_cond_op(e_type_i);

  for (genvar i = 0; i < N_ENT; i++) begin : g_pht
    sat_counter2 u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (upd_s && e_taken_s  && (e_pc_i[IDX_W-1:0] == IDX_W'(i))),
      .dec_i (upd_s && !e_taken_s && (e_pc_i[IDX_W-1:0] == IDX_W'(i))),
      .cnt_o (cnt_s[i])
    );
  end

  // Counters present their pre-update state, giving read-before-write.
  assign f_cnt_s    = cnt_s[f_pc_i[IDX_W-1:0]];
  assign pred_dir_s = f_cnt_s[1];
`else
  assign pred_dir_s = 1'b0;
`endif

  logic             p_valid_q, p_valid_d, p_taken_q, p_taken_d;
  logic [PC_W-1:0]  p_target_q, p_target_d;
  logic             r_valid_q, r_valid_d, r_taken_q, r_taken_d;
  logic             r_mispredict_q, r_mispredict_d;
  logic [PC_W-1:0]  r_target_q, r_target_d, r_redirect_q, r_redirect_d;
  logic [CNT_W-1:0] n_br_q, n_br_d, n_mp_q, n_mp_d;

  // Next-state: data outputs only load on a valid request, otherwise hold.
  always_comb begin
    p_valid_d      = f_valid_i;
    p_taken_d      = p_taken_q;
    p_target_d     = p_target_q;
    r_valid_d      = e_valid_i;
    r_taken_d      = r_taken_q;
    r_target_d     = r_target_q;
    r_mispredict_d = r_mispredict_q;
    r_redirect_d   = r_redirect_q;
    n_br_d         = n_br_q;
    n_mp_d         = n_mp_q;
    if (f_valid_i) begin
      p_taken_d  = f_uncond_i | pred_dir_s;
      p_target_d = p_taken_d ? calc_target(f_pc_i, f_offset_i) : (f_pc_i + PC_W'(1));
    end else begin
      p_taken_d  = p_taken_q;
    end
    if (e_valid_i) begin
      r_taken_d      = e_taken_s;
      r_target_d     = calc_target(e_pc_i, e_offset_i);
      r_mispredict_d = e_taken_s ^ e_pred_taken_i;
      r_redirect_d   = e_taken_s ? r_target_d : (e_pc_i + PC_W'(1));
      if (e_known_s) begin
        n_br_d = (n_br_q != CNT_MAX) ? (n_br_q + CNT_W'(1)) : n_br_q;
        if (r_mispredict_d && (n_mp_q != CNT_MAX)) begin
          n_mp_d = n_mp_q + CNT_W'(1);
        end else begin
          n_mp_d = n_mp_q;
        end
      end else begin
        n_br_d = n_br_q;
      end
    end else begin
      r_taken_d = r_taken_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q      <= 1'b0;
      p_taken_q      <= 1'b0;
      p_target_q     <= {PC_W{1'b0}};
      r_valid_q      <= 1'b0;
      r_taken_q      <= 1'b0;
      r_target_q     <= {PC_W{1'b0}};
      r_mispredict_q <= 1'b0;
      r_redirect_q   <= {PC_W{1'b0}};
      n_br_q         <= {CNT_W{1'b0}};
      n_mp_q         <= {CNT_W{1'b0}};
    end else begin
      p_valid_q      <= p_valid_d;
      p_taken_q      <= p_taken_d;
      p_target_q     <= p_target_d;
      r_valid_q      <= r_valid_d;
      r_taken_q      <= r_taken_d;
      r_target_q     <= r_target_d;
      r_mispredict_q <= r_mispredict_d;
      r_redirect_q   <= r_redirect_d;
      n_br_q         <= n_br_d;
      n_mp_q         <= n_mp_d;
    end
  end

  assign p_valid_o       = p_valid_q;
  assign p_taken_o       = p_taken_q;
  assign p_target_o      = p_target_q;
  assign r_valid_o       = r_valid_q;
  assign r_taken_o       = r_taken_q;
  assign r_target_o      = r_target_q;
  assign r_mispredict_o  = r_mispredict_q;
  assign r_redirect_pc_o = r_redirect_q;
  assign n_branches_o    = n_br_q;
  assign n_mispredicts_o = n_mp_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch unit. It adds a direct-mapped table of 2-bit saturating direction counters, a registered fetch-stage prediction, and a registered execute-stage resolution with mispredict/redirect. It sits between fetch, which gets the prediction and predicted target, and execute, which gets resolution and flush. It also keeps branch and mispredict performance counters.

## Interface
Parameters:
- PC_W, 16, PC and target width
- OFF_W, 16, branch offset width; sign-extended to PC_W when OFF_W < PC_W
- IDX_W, 4, table index bits; 2**IDX_W entries indexed by pc[IDX_W-1:0]
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch lookup request
- f_pc  in  PC_W  fetch PC
- f_offset  in  OFF_W  predecoded branch offset
- f_uncond  in  1  predecoded unconditional jump
- p_valid  out  1  prediction valid, one cycle after f_valid
- p_taken  out  1  predicted direction
- p_target  out  PC_W  predicted next PC
- e_valid  in  1  branch resolving in execute
- e_pc  in  PC_W  branch PC
- e_type  in  4  branch opcode (OP_JMP, OP_BRZ, OP_BRNZ, OP_BRNS)
- e_offset  in  OFF_W  branch offset
- e_flags  in  4  stored flags; bit0 = Z, bit1 = N
- e_pred_taken  in  1  prediction carried down the pipe
- r_valid  out  1  resolution valid, one cycle after e_valid
- r_taken  out  1  actual direction
- r_target  out  PC_W  pc+1+sext(offset)
- r_mispredict  out  1  r_taken differs from e_pred_taken; r_valid qualifies it
- r_redirect_pc  out  PC_W  correct next PC: r_target if taken, else pc+1
- n_branches  out  CNT_W  resolved branch count
- n_mispredicts  out  CNT_W  mispredict count

## Operation
- Target arithmetic is the same on both paths: pc + 1 + sext(offset), modulo 2**PC_W, with wrap-around allowed.
- Prediction:
  - Unconditional (f_uncond): p_taken = 1.
  - Otherwise p_taken = table[f_pc idx][1].
  - p_target is the computed target when p_taken = 1, else f_pc+1.
- Resolution rules:
  - OP_JMP: taken.
  - OP_BRZ: taken when Z = 1.
  - OP_BRNZ: taken when Z = 0.
  - OP_BRNS: taken when N = 0.
  - Any other e_type: not taken, no table update, no count; r_valid is still asserted.
- Table update happens on e_valid with a conditional type only.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Performance counters:
  - n_branches increments on every e_valid with a known type.
  - n_mispredicts increments when r_mispredict is also set.
  - Both saturate at all-ones; neither wraps.

## Timing
- Reset values:
  - All table entries are 01.
  - p_valid, p_taken, r_valid, r_taken, r_mispredict are 0.
  - p_target, r_target, r_redirect_pc are 0.
  - Both performance counters are 0.
- Reset mid-operation clears everything within the same cycle, because reset is asynchronous. In-flight results are dropped.
- Lookup latency is 1 cycle; resolve latency is 1 cycle. Both paths are fully pipelined and accept a request every cycle.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update value (read-before-write). The updated value is visible to a lookup the following cycle.
- Without e_valid, the table and counters hold. r_valid and p_valid each drop to 0 the cycle after their request input deasserts; data outputs hold their last value.

## Configuration
- BRANCH_PREDICT_EN defined: the table and the behaviour above are built.
- BRANCH_PREDICT_EN undefined:
  - No table is instantiated.
  - Conditional branches predict not-taken; unconditional branches still predict taken.
  - The resolution path and performance counters are unchanged.

## Structure
- Shared package/defines:
  - OP_JMP, OP_BRZ, OP_BRNZ, OP_BRNS.
  - Flag bit positions FLAG_Z = 0 and FLAG_N = 1.
  - Counter state constants SC_SNT, SC_WNT, SC_WT, SC_ST.
- Sub-module sat_counter2: one 2-bit saturating counter with inc/dec enables. It is instantiated per entry through a generate loop.

## Test plan
- Reset, then lookup f_pc=0x0010, f_offset=0x0005, cond -> p_taken=0, p_target=0x0011.
- Resolve OP_BRZ, e_pc=0x0100, e_offset=0x000A, flags=0001, pred=0 -> r_taken=1, r_target=0x010B, r_redirect_pc=0x010B, r_mispredict=1, n_mispredicts=1.
- Resolve OP_BRNS taken twice on PC 0x0010, then look up 0x0010 -> p_taken=1. Resolve not-taken three times -> entry 00 and p_taken=0.
- OP_JMP, e_pc=0x1000, e_offset=0xFFFE -> r_target=0x0FFF, r_taken=1, no table change. Also e_pc=0xFFFF with offset 0 -> r_target=0x0000, showing wrap.
- Same-cycle update and lookup on the same index while the entry is 01 and the branch is taken -> p_taken=0 that cycle, p_taken=1 on a lookup the next cycle.
- Assert rst_n low mid-stream with r_valid=1 -> all outputs 0 immediately and counters 0. Build without BRANCH_PREDICT_EN -> conditional lookups always give p_taken=0.
